uart_rx: RTL and testbench

//  Serial receiver mating with uart_tx: recovers 8N1 frames from the line driven by
//  o_uart_tx (loopback or host link) and buffers bytes in a small FIFO. Consumer

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF input synchroniser, start-bit glitch rejection,
// mid-bit sampling and a small byte FIFO drained through a valid/ready handshake.
module uart_rx #(
  parameter int unsigned UART_CLK_DIV = 434,
  parameter int unsigned FIFO_ASIZE   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  output logic       rvalid,
  input  logic       rready,
  output logic [7:0] rdata,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned CNT_W = $clog2(UART_CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(UART_CLK_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UART_CLK_DIV - 1);
  localparam int unsigned DEPTH = 2 ** FIFO_ASIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             push, fe_n;
  logic             rx_m, rx_s;

  logic [FIFO_ASIZE-1:0] wr_ptr, rd_ptr, wr_inc;
  logic [7:0]            mem [DEPTH];
  logic                  full, pop, wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
    end
  end

  // Leaving STOP at the stop-bit centre gives half a bit of slack, so a start
  // bit immediately following the stop bit is still caught in IDLE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    push    = 1'b0;
    fe_n    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_n = S_IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign wr_inc = wr_ptr + FIFO_ASIZE'(1);
  assign full   = (wr_inc == rd_ptr);
  assign rvalid = (wr_ptr != rd_ptr);
  assign pop    = rvalid & rready;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign wr_en  = push & (~full | pop);
  assign rdata  = rvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_inc;
      if (pop)   rd_ptr <= rd_ptr + FIFO_ASIZE'(1);
      frame_err <= fe_n;
      overflow  <= push & ~wr_en;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bytes are queued when their frames are driven and
// compared against rdata whenever the consumer handshake pops one.
module tb_uart_rx;

  localparam int unsigned DIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic       rready = 1'b0;
  logic       rvalid;
  logic [7:0] rdata;
  logic       frame_err;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  logic [7:0] exp_q [$];

  uart_rx #(.UART_CLK_DIV(DIV), .FIFO_ASIZE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_uart_rx(rx_line),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedges; outputs sampled 2 ns later, before the next posedge.
  always @(negedge clk) begin
    #2;
    if (frame_err === 1'b1) fe_cnt++;
    if (overflow === 1'b1) ov_cnt++;
    if (rvalid === 1'b1 && rready === 1'b1) begin
      check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Caller must be aligned to a negedge; ends aligned to a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = bits[i];
      repeat (DIV) @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  task automatic wait_rvalid(input int limit, input string tag);
    int n = 0;
    while (rvalid !== 1'b1 && n < limit) begin
      @(negedge clk);
      #3;
      n++;
    end
    check(tag, 32'(rvalid), 32'd1);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    #3;
  endtask

  task automatic drain(input int limit, input string tag);
    int n = 0;
    @(negedge clk);
    rready = 1'b1;
    while (rvalid === 1'b1 && n < limit) begin
      @(negedge clk);
      #3;
      n++;
    end
    rready = 1'b0;
    check(tag, 32'(rvalid), 32'd0);
  endtask

  initial begin
    int lat;
    int fe0, ov0;
    logic [7:0] b81;
    bit done;

    repeat (3) @(negedge clk);
    #3;
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single frame, latency from pin falling edge to rvalid
    exp_q.push_back(8'h41);
    @(negedge clk);
    fork
      send_frame(8'h41, 1'b1);
      begin
        lat = 0;
        while (rvalid !== 1'b1 && lat < 200) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    check("t1_latency_in_window", 32'(lat >= 79 && lat <= 81), 32'd1);
    #3;
    check("t1_rvalid", 32'(rvalid), 32'd1);
    check("t1_rdata_held", 32'(rdata), 32'h41);
    check("t1_no_frame_err", 32'(fe_cnt), 32'd0);
    check("t1_no_overflow", 32'(ov_cnt), 32'd0);
    pop_one();
    check("t1_rvalid_after_pop", 32'(rvalid), 32'd0);

    // 2: 3-clock low glitch is rejected, next frame still received
    @(negedge clk);
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    #3;
    check("t2_glitch_no_push", 32'(rvalid), 32'd0);
    check("t2_glitch_no_flags", 32'(fe_cnt + ov_cnt), 32'd0);
    exp_q.push_back(8'hA5);
    @(negedge clk);
    send_frame(8'hA5, 1'b1);
    wait_rvalid(20, "t2_rvalid");
    pop_one();
    check("t2_rvalid_after_pop", 32'(rvalid), 32'd0);

    // 3: bad stop bit, line held low, then a good frame
    fe0 = fe_cnt;
    @(negedge clk);
    send_frame(8'h3C, 1'b0);
    rx_line = 1'b0;
    repeat (40) @(negedge clk);
    rx_line = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    check("t3_one_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("t3_no_push", 32'(rvalid), 32'd0);
    exp_q.push_back(8'h55);
    @(negedge clk);
    send_frame(8'h55, 1'b1);
    wait_rvalid(20, "t3_rvalid");
    check("t3_rdata", 32'(rdata), 32'h55);
    pop_one();
    check("t3_single_byte", 32'(rvalid), 32'd0);

    // 4: 16 back-to-back frames into a 15-deep FIFO
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    for (int i = 0; i < 15; i++) exp_q.push_back(8'(i));
    @(negedge clk);
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    repeat (10) @(negedge clk);
    #3;
    check("t4_one_overflow", 32'(ov_cnt - ov0), 32'd1);
    check("t4_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("t4_rvalid_full", 32'(rvalid), 32'd1);
    check("t4_head_byte", 32'(rdata), 32'h00);
    drain(100, "t4_drained");
    check("t4_all_popped", 32'(exp_q.size()), 32'd0);

    // 5: 256 back-to-back bytes with a randomly stalling consumer
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    done = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          rready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        rready = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    drain(100, "t5_drained");
    check("t5_all_bytes", 32'(exp_q.size()), 32'd0);
    check("t5_no_flags", 32'((ov_cnt - ov0) + (fe_cnt - fe0)), 32'd0);

    // 6: reset during data bit 4 with one byte already buffered
    exp_q.push_back(8'h11);
    @(negedge clk);
    send_frame(8'h11, 1'b1);
    wait_rvalid(20, "t6_preload_rvalid");
    b81 = 8'h81;
    @(negedge clk);
    rx_line = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_line = b81[i];
      repeat (DIV) @(negedge clk);
    end
    rx_line = b81[4];
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #3;
    check("t6_reset_rvalid", 32'(rvalid), 32'd0);
    check("t6_reset_rdata", 32'(rdata), 32'd0);
    check("t6_reset_flags", 32'({frame_err, overflow}), 32'd0);
    @(negedge clk);
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    check("t6_no_partial_byte", 32'(rvalid), 32'd0);
    exp_q.push_back(8'h7E);
    @(negedge clk);
    send_frame(8'h7E, 1'b1);
    wait_rvalid(20, "t6_rvalid");
    check("t6_rdata", 32'(rdata), 32'h7E);
    pop_one();
    check("t6_empty_after_pop", 32'(rvalid), 32'd0);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
